// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART transmitter.
// SPART_TX_PARITY_EN adds the PARITY state and the even-parity helper.
package spart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  localparam logic [1:0] IOADDR_BUF  = 2'b00;
  localparam logic [1:0] IOADDR_STAT = 2'b01;

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;
`endif

endpackage

// File: rtl/spart_bit_timer.sv
// Oversample tick counter; bit_end marks the enable pulse that closes a bit period.
module spart_bit_timer
  import spart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic bit_end
);

  logic [TICK_W-1:0] tick_q, tick_d;

  // Tick counter next value; the last tick wraps to zero on its own
  always_comb begin
    if (clear) begin
      tick_d = '0;
    end else if (enable) begin
      tick_d = tick_q + TICK_W'(1);
    end else begin
      tick_d = tick_q;
    end
  end

  // Tick counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign bit_end = enable & ~clear & (tick_q == TICK_LAST);

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: one-byte holding buffer feeding an 8N1 serial frame.
// Define SPART_TX_PARITY_EN to send an even-parity bit between data and stop.
module spart_tx
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tbr
);

  tx_state_e  state_q, state_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_empty_q, buf_empty_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       txd_q, txd_d;
  logic       wr_s, load_s, bit_end_s, timer_clear_s;
`ifdef SPART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  assign wr_s          = iocs & ~iorw & (ioaddr == IOADDR_BUF);
  assign timer_clear_s = (state_q == TX_IDLE);
  // Buffer moves to the shifter from IDLE, or straight from a finishing STOP
  assign load_s        = ~buf_empty_q &
                         ((state_q == TX_IDLE) | ((state_q == TX_STOP) & bit_end_s));

  spart_bit_timer u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .clear   (timer_clear_s),
    .bit_end (bit_end_s)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TX_IDLE;
      buf_q       <= 8'h00;
      buf_empty_q <= 1'b1;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      txd_q       <= 1'b1;
`ifdef SPART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_empty_q <= buf_empty_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      txd_q       <= txd_d;
`ifdef SPART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Next state, shifter and bit counter
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      TX_IDLE: begin
        if (load_s) begin
          state_d   = TX_START;
          shift_d   = buf_q;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (bit_end_s) state_d = TX_DATA;
        else           state_d = TX_START;
      end
      TX_DATA: begin
        if (bit_end_s) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef SPART_TX_PARITY_EN
          if (bit_cnt_q == 3'd7) state_d = TX_PARITY;
          else                   state_d = TX_DATA;
`else
          if (bit_cnt_q == 3'd7) state_d = TX_STOP;
          else                   state_d = TX_DATA;
`endif
        end else begin
          state_d = TX_DATA;
        end
      end
`ifdef SPART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end_s) state_d = TX_STOP;
        else           state_d = TX_PARITY;
      end
`endif
      TX_STOP: begin
        if (load_s) begin
          state_d   = TX_START;
          shift_d   = buf_q;
          bit_cnt_d = 3'd0;
        end else if (bit_end_s) begin
          state_d = TX_IDLE;
        end else begin
          state_d = TX_STOP;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // Holding buffer; a load and an accepted write can never coincide
  always_comb begin
    if (load_s) begin
      buf_d       = buf_q;
      buf_empty_d = 1'b1;
    end else if (wr_s && buf_empty_q) begin
      buf_d       = tx_data;
      buf_empty_d = 1'b0;
    end else begin
      buf_d       = buf_q;
      buf_empty_d = buf_empty_q;
    end
`ifdef SPART_TX_PARITY_EN
    if (load_s) par_d = even_parity(buf_q);
    else        par_d = par_q;
`endif
  end

  // Serial line value for the upcoming state, registered for a glitch-free txd
  always_comb begin
    case (state_d)
      TX_IDLE:   txd_d = 1'b1;
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = shift_d[0];
`ifdef SPART_TX_PARITY_EN
      TX_PARITY: txd_d = par_d;
`endif
      TX_STOP:   txd_d = 1'b1;
      default:   txd_d = 1'b1;
    endcase
  end

  assign txd = txd_q;
  assign tbr = buf_empty_q;

endmodule
